// File: rtl/lsu_if.sv
// Execution-unit request/response and memory command/response signals of the LSU.
// slave is the LSU's view; master is the surrounding system's view.
interface lsu_if;
    logic        hs_ex4ls_val;
    logic        hs_ls4ex_rdy;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic [31:0] o_ls_rdat;
    logic        o_ls_err;
    logic        o_mem_val;
    logic        i_mem_rdy;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_wdat;
    logic [3:0]  o_mem_wen;
    logic        o_mem_ren;
    logic        i_mem_rsp_val;
    logic [31:0] i_mem_rdat;

    modport slave (
        input  hs_ex4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        input  i_mem_rdy, i_mem_rsp_val, i_mem_rdat,
        output hs_ls4ex_rdy, o_ls_rdat, o_ls_err,
        output o_mem_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren
    );

    modport master (
        output hs_ex4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        output i_mem_rdy, i_mem_rsp_val, i_mem_rdat,
        input  hs_ls4ex_rdy, o_ls_rdat, o_ls_err,
        input  o_mem_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one execution-unit access at a time, issues a single word-aligned
// memory command, waits (bounded by TMO_CYC) for the response and returns a one-cycle result.
module lsu #(
    parameter int unsigned TMO_CYC = 255
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam int unsigned CW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TmoVal = CW'(TMO_CYC);

    typedef enum logic [1:0] {StIdle, StCmd, StRsp, StDone} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   adr_q;
    logic [31:0]   wdat_q;
    logic [3:0]    wen_q;
    logic          ren_q;
    logic          mem_val_q;
    logic          rdy_q;
    logic [31:0]   rdat_q;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            wen_q     <= '0;
            ren_q     <= 1'b0;
            mem_val_q <= 1'b0;
            rdy_q     <= 1'b0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.hs_ex4ls_val) begin
                        adr_q  <= bus.i_ls_adr;
                        wdat_q <= bus.i_ls_wdat;
                        wen_q  <= bus.i_ls_wen;
                        ren_q  <= bus.i_ls_ren;
                        if (bus.i_ls_ren ^ (bus.i_ls_wen != 4'b0)) begin
                            state_q   <= StCmd;
                            mem_val_q <= 1'b1;
                        end else begin
                            // No-op completes cleanly; read+write together is rejected.
                            state_q <= StDone;
                            rdy_q   <= 1'b1;
                            rdat_q  <= '0;
                            err_q   <= bus.i_ls_ren && (bus.i_ls_wen != 4'b0);
                        end
                    end
                end
                StCmd: begin
                    if (bus.i_mem_rdy) begin
                        state_q   <= StRsp;
                        mem_val_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                StRsp: begin
                    // A response in the final counted cycle beats the timeout.
                    if (bus.i_mem_rsp_val) begin
                        state_q <= StDone;
                        rdy_q   <= 1'b1;
                        rdat_q  <= ren_q ? bus.i_mem_rdat : 32'h0;
                        err_q   <= 1'b0;
                    end else if (cnt_q + CW'(1) == TmoVal) begin
                        state_q <= StDone;
                        cnt_q   <= cnt_q + CW'(1);
                        rdy_q   <= 1'b1;
                        rdat_q  <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    rdy_q   <= 1'b0;
                    rdat_q  <= '0;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.hs_ls4ex_rdy = rdy_q;
    assign bus.o_ls_rdat    = rdat_q;
    assign bus.o_ls_err     = err_q;
    assign bus.o_mem_val    = mem_val_q;
    assign bus.o_mem_adr    = {adr_q[31:2], 2'b00};
    assign bus.o_mem_wdat   = wdat_q;
    assign bus.o_mem_wen    = wen_q;
    assign bus.o_mem_ren    = ren_q;

    logic unused_adr_lsb;
    assign unused_adr_lsb = ^adr_q[1:0];
endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu: the driver pushes expected memory commands and
// completions (with their cycle numbers); a negedge monitor pops and compares them.
module tb_lsu;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic        ren;
        int          cyc;
    } cmd_t;

    typedef struct {
        logic [31:0] rdat;
        logic        err;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    lsu_if bus();

    lsu #(.TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Payload changes after acceptance must be invisible to the memory side.
    task automatic scramble();
        bus.i_ls_adr  = $urandom;
        bus.i_ls_wdat = $urandom;
        bus.i_ls_wen  = 4'($urandom_range(0, 15));
        bus.i_ls_ren  = 1'($urandom_range(0, 1));
    endtask

    // Starts in a cycle where the LSU is idle; returns in the cycle after the completion.
    task automatic do_req(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] wen,
                          input logic ren, input int d1, input int d2, input logic [31:0] rd,
                          input logic hold);
        int   n;
        int   k_end;
        bit   is_mem;
        bit   tmo;
        cmd_t c;
        rsp_t r;
        n = cyc;
        bus.hs_ex4ls_val = 1'b1;
        bus.i_ls_adr     = adr;
        bus.i_ls_wdat    = wdat;
        bus.i_ls_wen     = wen;
        bus.i_ls_ren     = ren;
        is_mem = (ren && wen == 4'h0) || (!ren && wen != 4'h0);
        k_end  = 0;
        if (is_mem) begin
            c.adr  = {adr[31:2], 2'b00};
            c.wdat = wdat;
            c.wen  = wen;
            c.ren  = ren;
            c.cyc  = n + 1 + d1;
            cmd_q.push_back(c);
            tmo    = (d2 + 1 > TMO);
            k_end  = tmo ? TMO : d2 + 1;
            r.rdat = (tmo || !ren) ? 32'h0 : rd;
            r.err  = tmo;
            r.cyc  = n + 2 + d1 + k_end;
        end else begin
            r.rdat = 32'h0;
            r.err  = ren && (wen != 4'h0);
            r.cyc  = n + 1;
        end
        rsp_q.push_back(r);
        step();
        bus.hs_ex4ls_val = 1'b0;
        scramble();
        if (is_mem) begin
            for (int i = 0; i <= d1; i++) begin
                bus.i_mem_rdy     = (i == d1);
                bus.i_mem_rsp_val = 1'($urandom_range(0, 1));
                bus.i_mem_rdat    = $urandom;
                step();
                scramble();
            end
            for (int k = 1; k <= k_end; k++) begin
                bus.i_mem_rdy     = 1'($urandom_range(0, 1));
                bus.i_mem_rsp_val = (k == d2 + 1);
                bus.i_mem_rdat    = (k == d2 + 1) ? rd : 32'($urandom);
                step();
            end
        end
        // Completion cycle: stray response and a held request must both be ignored.
        bus.i_mem_rdy     = 1'b0;
        bus.i_mem_rsp_val = 1'($urandom_range(0, 1));
        bus.i_mem_rdat    = $urandom;
        bus.hs_ex4ls_val  = hold;
        scramble();
        step();
        bus.hs_ex4ls_val  = 1'b0;
        bus.i_mem_rsp_val = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_mem_val) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_mem_val", 64'(bus.o_mem_val), 64'(0));
                end else begin
                    chk("mem_adr", 64'(bus.o_mem_adr), 64'(cmd_q[0].adr));
                    chk("mem_wdat", 64'(bus.o_mem_wdat), 64'(cmd_q[0].wdat));
                    chk("mem_wen", 64'(bus.o_mem_wen), 64'(cmd_q[0].wen));
                    chk("mem_ren", 64'(bus.o_mem_ren), 64'(cmd_q[0].ren));
                    if (bus.i_mem_rdy) begin
                        chk("mem_accept_cycle", 64'(cyc), 64'(cmd_q[0].cyc));
                        void'(cmd_q.pop_front());
                    end
                end
            end
            if (bus.hs_ls4ex_rdy) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rdy", 64'(bus.hs_ls4ex_rdy), 64'(0));
                end else begin
                    chk("rdat", 64'(bus.o_ls_rdat), 64'(rsp_q[0].rdat));
                    chk("err", 64'(bus.o_ls_err), 64'(rsp_q[0].err));
                    chk("rdy_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
                    void'(rsp_q.pop_front());
                end
            end else begin
                chk("idle_rdat", 64'(bus.o_ls_rdat), 64'(0));
                chk("idle_err", 64'(bus.o_ls_err), 64'(0));
            end
        end
    end

    initial begin
        bus.hs_ex4ls_val  = 1'b0;
        bus.i_ls_adr      = '0;
        bus.i_ls_wdat     = '0;
        bus.i_ls_wen      = '0;
        bus.i_ls_ren      = 1'b0;
        bus.i_mem_rdy     = 1'b0;
        bus.i_mem_rsp_val = 1'b0;
        bus.i_mem_rdat    = '0;
        rst = 1'b1;
        step();
        step();
        chk("reset_rdy", 64'(bus.hs_ls4ex_rdy), 64'(0));
        chk("reset_mem_val", 64'(bus.o_mem_val), 64'(0));
        chk("reset_rdat", 64'(bus.o_ls_rdat), 64'(0));
        chk("reset_err", 64'(bus.o_ls_err), 64'(0));
        chk("reset_mem_adr", 64'(bus.o_mem_adr), 64'(0));
        rst = 1'b0;
        step();

        // Directed cases.
        do_req(32'h0000_1003, 32'h0, 4'h0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0);
        do_req(32'h0000_2002, 32'h1234_5678, 4'b0011, 1'b0, 3, 0, 32'h0, 1'b0);
        do_req(32'h0000_3000, 32'h0, 4'h0, 1'b1, 0, 20, 32'h5555_AAAA, 1'b0);
        do_req(32'h0000_3004, 32'h0, 4'h0, 1'b1, 0, TMO - 1, 32'hCAFE_F00D, 1'b0);
        do_req(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 0, 32'h0, 1'b0);
        do_req(32'h0000_5000, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0, 1'b0);
        do_req(32'h0000_6001, 32'h0, 4'h0, 1'b1, 1, 1, 32'h0BAD_CAFE, 1'b1);
        do_req(32'h0000_7003, 32'hA5A5_5A5A, 4'b1000, 1'b0, 0, 2, 32'h0, 1'b1);

        // Reset while waiting for a response: no completion, later stray response ignored.
        bus.hs_ex4ls_val = 1'b1;
        bus.i_ls_adr     = 32'h0000_8008;
        bus.i_ls_wdat    = 32'h0;
        bus.i_ls_wen     = 4'h0;
        bus.i_ls_ren     = 1'b1;
        begin
            cmd_t c;
            c.adr  = 32'h0000_8008;
            c.wdat = 32'h0;
            c.wen  = 4'h0;
            c.ren  = 1'b1;
            c.cyc  = cyc + 1;
            cmd_q.push_back(c);
        end
        step();
        bus.hs_ex4ls_val = 1'b0;
        bus.i_mem_rdy    = 1'b1;
        step();
        bus.i_mem_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_rdy", 64'(bus.hs_ls4ex_rdy), 64'(0));
        chk("rst_mid_mem_val", 64'(bus.o_mem_val), 64'(0));
        bus.i_mem_rsp_val = 1'b1;
        bus.i_mem_rdat    = 32'h1111_2222;
        step();
        step();
        bus.i_mem_rsp_val = 1'b0;
        step();
        do_req(32'h0000_9000, 32'h0, 4'h0, 1'b1, 0, 0, 32'h3333_4444, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            int          kind;
            logic [3:0]  wen;
            logic        ren;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                ren = 1'b1;
                wen = 4'h0;
            end else if (kind < 8) begin
                ren = 1'b0;
                wen = 4'($urandom_range(1, 15));
            end else if (kind == 8) begin
                ren = 1'b1;
                wen = 4'($urandom_range(1, 15));
            end else begin
                ren = 1'b0;
                wen = 4'h0;
            end
            do_req($urandom, $urandom, wen, ren, $urandom_range(0, 3), $urandom_range(0, 6),
                   $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        step();
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
